div_arbiter: RTL

- Shares one combinational 4-bit division unit between two requesters, using round-robin arbitration and valid/ready handshakes.
- Latches operands and holds them on the divider for a programmable settle time. Captures quotient, remainder and validity into one registered response port, with one operation outstanding at a time.
- Sits between the ALU issue logic and the division datapath. The divider's ports connect directly to the div_* ports.

---
 rtl/div_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin sharing of one combinational divider between two valid/ready requesters
module div_arbiter #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [WIDTH-1:0]     req0_dividend,
  input  logic [WIDTH-1:0]     req0_divisor,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [WIDTH-1:0]     req1_dividend,
  input  logic [WIDTH-1:0]     req1_divisor,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [WIDTH-1:0]     rsp_quotient,
  output logic [WIDTH-1:0]     rsp_remainder,
  output logic                 rsp_err,
  output logic [WIDTH-1:0]     div_dividend,
  output logic [WIDTH-1:0]     div_divisor,
  input  logic [WIDTH-1:0]     div_quotient,
  input  logic [WIDTH-1:0]     div_remainder,
  input  logic                 div_valid,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] done_count
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t               state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic                 id_q, id_d;
  logic [WIDTH-1:0]     dividend_q, dividend_d;
  logic [WIDTH-1:0]     divisor_q, divisor_d;
  logic [WIDTH-1:0]     quotient_q, quotient_d;
  logic [WIDTH-1:0]     remainder_q, remainder_d;
  logic                 err_q, err_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] done_count_q, done_count_d;
  logic                 grant1;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      dividend_q   <= '0;
      divisor_q    <= '0;
      quotient_q   <= '0;
      remainder_q  <= '0;
      err_q        <= 1'b0;
      rsp_valid_q  <= 1'b0;
      cnt_q        <= '0;
      done_count_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      dividend_q   <= dividend_d;
      divisor_q    <= divisor_d;
      quotient_q   <= quotient_d;
      remainder_q  <= remainder_d;
      err_q        <= err_d;
      rsp_valid_q  <= rsp_valid_d;
      cnt_q        <= cnt_d;
      done_count_q <= done_count_d;
    end
  end
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    dividend_d   = dividend_q;
    divisor_d    = divisor_q;
    quotient_d   = quotient_q;
    remainder_d  = remainder_q;
    err_d        = err_q;
    rsp_valid_d  = rsp_valid_q;
    cnt_d        = cnt_q;
    done_count_d = done_count_q;
    case (state_q)
      IDLE: if (req0_ready | req1_ready) begin
        state_d      = WAIT;
        id_d         = req1_ready;
        last_grant_d = req1_ready;
        dividend_d   = req1_ready ? req1_dividend : req0_dividend;
        divisor_d    = req1_ready ? req1_divisor : req0_divisor;
        cnt_d        = 4'(SETTLE_CYCLES - 1);
      end
      WAIT: if (cnt_q == '0) begin
        state_d     = RESP;
        quotient_d  = div_quotient;
        remainder_d = div_remainder;
        err_d       = ~div_valid;
        rsp_valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      RESP: if (rsp_ready) begin
        state_d      = IDLE;
        rsp_valid_d  = 1'b0;
        done_count_d = done_count_q + CNT_WIDTH'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    grant1        = req1_valid & (~req0_valid | ~last_grant_q);
    req0_ready    = (state_q == IDLE) & req0_valid & ~grant1;
    req1_ready    = (state_q == IDLE) & grant1;
    busy          = state_q != IDLE;
    rsp_valid     = rsp_valid_q;
    rsp_id        = id_q;
    rsp_quotient  = quotient_q;
    rsp_remainder = remainder_q;
    rsp_err       = err_q;
    div_dividend  = dividend_q;
    div_divisor   = divisor_q;
    done_count    = done_count_q;
  end
endmodule
